// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the logic_unit_pipe slice: operation encodings and
// default widths.
package logic_unit_pipe_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_ANDN = 3'b111
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise operation mux: result = op(sel)(a, b).
module logic_unit_core
  import logic_unit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result
);

  // Select the bitwise function of a and b.
  always_comb begin
    result = '0;
    case (op_e'(sel))
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_NOTA: result = ~a;
      OP_ANDN: result = a & ~b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready handshakes, an accumulator
// for chained operations, result flags and a completed-result counter.
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       sel,
  input  logic             chain,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [2:0]       sel_q, sel_d;
  logic             chain_q, chain_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_load;
  logic             accept;
  logic             out_xfer;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;

  assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign accept   = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;
  assign op_a     = chain_q ? acc_q : in1_q;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a      (op_a),
    .b      (in2_q),
    .sel    (sel_q),
    .result (result)
  );

  // Stage 1 next state: operands are captured only on an accepted beat so
  // idle-cycle garbage never enters the pipeline.
  always_comb begin
    s1_valid_d = s1_valid_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    sel_d      = sel_q;
    chain_d    = chain_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      in1_d      = in1;
      in2_d      = in2;
      sel_d      = sel;
      chain_d    = chain;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: result, flags, accumulator and transfer counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    parity_d    = parity_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_d       = result;
      zero_d      = (result == '0);
      ones_d      = (result == '1);
      parity_d    = ^result;
      acc_d       = result;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (acc_clr) begin
      acc_d = '0;
    end
    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      sel_q       <= '0;
      chain_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      parity_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      sel_q       <= sel_d;
      chain_q     <= chain_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      parity_q    <= parity_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign out_zero   = zero_q;
  assign out_ones   = ones_q;
  assign out_parity = parity_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8). A second
// instance with CNT_W=4 shares all inputs to exercise counter wrap.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in1 = '0;
  logic [7:0] in2 = '0;
  logic [2:0] sel = '0;
  logic       chain = 1'b0;
  logic       acc_clr = 1'b0;
  logic       out_ready = 1'b1;

  logic        in_ready, out_valid, out_zero, out_ones, out_parity;
  logic [7:0]  out;
  logic [15:0] op_count;

  logic        in_ready2, out_valid2, out_zero2, out_ones2, out_parity2;
  logic [7:0]  out2;
  logic [3:0]  op_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sel(sel), .chain(chain), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
    .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in1(in1), .in2(in2), .sel(sel), .chain(chain), .acc_clr(acc_clr),
    .out_valid(out_valid2), .out_ready(out_ready), .out(out2),
    .out_zero(out_zero2), .out_ones(out_ones2), .out_parity(out_parity2),
    .op_count(op_count2)
  );

  task automatic test_reset();
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if ({out, out_zero, out_ones, out_parity} !== 11'h0) begin fails++; $display("FAIL reset_out_flags got %h exp 0", {out, out_zero, out_ones, out_parity}); end
    tests++; if (op_count !== 16'd0) begin fails++; $display("FAIL reset_op_count got %0d exp 0", op_count); end
    rst = 1'b0;
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_v [8];
    exp_v = '{8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'h5A, 8'h81};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 10) begin
        tests++; if (out_valid !== 1'b1 || out !== exp_v[i-2]) begin fails++; $display("FAIL ops_out[%0d] got v=%b %h exp v=1 %h", i-2, out_valid, out, exp_v[i-2]); end
        tests++; if (out_parity !== ^exp_v[i-2]) begin fails++; $display("FAIL ops_parity[%0d] got %b exp %b", i-2, out_parity, ^exp_v[i-2]); end
      end
      if (i < 8) begin
        in_valid = 1'b1; in1 = 8'hA5; in2 = 8'h3C; sel = 3'(i); chain = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ops_in_ready[%0d] got %b exp 1", i, in_ready); end
      end else begin
        in_valid = 1'b0; in1 = 'x; in2 = 'x; sel = 'x;
      end
      if (i == 10) begin
        tests++; if (op_count !== 16'd8 || out_valid !== 1'b0) begin fails++; $display("FAIL ops_count got %0d v=%b exp 8 v=0", op_count, out_valid); end
      end
    end
  endtask

  task automatic test_chain();
    @(negedge clk);
    in_valid = 1'b1; in1 = 8'hF0; in2 = 8'hFF; sel = 3'b000; chain = 1'b0;
    @(negedge clk);
    in1 = 8'h00; in2 = 8'h0F; sel = 3'b010; chain = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out !== 8'hF0) begin fails++; $display("FAIL chain_first got v=%b %h exp v=1 f0", out_valid, out); end
    in_valid = 1'b0; in1 = 'x; in2 = 'x; sel = 'x; chain = 1'b0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out !== 8'hFF) begin fails++; $display("FAIL chain_second got v=%b %h exp v=1 ff", out_valid, out); end
    tests++; if ({out_zero, out_ones, out_parity} !== 3'b010) begin fails++; $display("FAIL chain_flags got %b exp 010", {out_zero, out_ones, out_parity}); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] beats [4];
    logic       exp_rdy [10];
    logic       exp_ov [10];
    logic [7:0] exp_out [10];
    logic [15:0] base;
    int idx;
    beats   = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_out = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    idx = 0;
    base = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) base = op_count;
      tests++; if (out_valid !== exp_ov[c]) begin fails++; $display("FAIL bp_out_valid[%0d] got %b exp %b", c, out_valid, exp_ov[c]); end
      if (exp_ov[c]) begin
        tests++; if (out !== exp_out[c]) begin fails++; $display("FAIL bp_out[%0d] got %h exp %h", c, out, exp_out[c]); end
      end
      if (c == 5) begin
        tests++; if (op_count !== base) begin fails++; $display("FAIL bp_count_hold got %0d exp %0d", op_count, base); end
      end
      out_ready = (c >= 5);
      if (idx < 4) begin
        in_valid = 1'b1; in1 = beats[idx]; in2 = 8'h00; sel = 3'b001; chain = 1'b0;
      end else begin
        in_valid = 1'b0; in1 = 'x; in2 = 'x; sel = 'x;
      end
      #1;
      tests++; if (in_ready !== exp_rdy[c]) begin fails++; $display("FAIL bp_in_ready[%0d] got %b exp %b", c, in_ready, exp_rdy[c]); end
      if (in_valid && in_ready) idx++;
      if (c == 9) begin
        tests++; if (op_count !== base + 16'd4) begin fails++; $display("FAIL bp_count got %0d exp %0d", op_count, base + 16'd4); end
      end
    end
  endtask

  task automatic test_acc_clr();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in1 = 8'h5A; in2 = 8'hFF; sel = 3'b000; chain = 1'b0;
    @(negedge clk);
    in2 = 8'h0F; sel = 3'b001; chain = 1'b1;
    @(negedge clk);
    tests++; if (out !== 8'h5A) begin fails++; $display("FAIL clr_base got %h exp 5a", out); end
    in2 = 8'h00; sel = 3'b001; chain = 1'b1; acc_clr = 1'b1;
    @(negedge clk);
    tests++; if (out !== 8'h5F) begin fails++; $display("FAIL clr_old_acc got %h exp 5f", out); end
    acc_clr = 1'b0; in_valid = 1'b0; in1 = 'x; in2 = 'x; sel = 'x; chain = 1'b0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out !== 8'h00 || out_zero !== 1'b1) begin fails++; $display("FAIL clr_zero got v=%b %h z=%b exp v=1 00 z=1", out_valid, out, out_zero); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in1 = 8'h77; in2 = 8'hFF; sel = 3'b000; chain = 1'b0;
    @(negedge clk);
    in1 = 8'h66;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out !== 8'h77) begin fails++; $display("FAIL rstmf_pre got v=%b %h exp v=1 77", out_valid, out); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({out_valid, out, out_zero, out_ones, out_parity} !== 12'h0) begin fails++; $display("FAIL rstmf_outputs got %h exp 0", {out_valid, out, out_zero, out_ones, out_parity}); end
    tests++; if (in_ready !== 1'b1 || op_count !== 16'd0) begin fails++; $display("FAIL rstmf_ready_count got r=%b c=%0d exp r=1 c=0", in_ready, op_count); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || op_count !== 16'd0) begin fails++; $display("FAIL rstmf_stale[%0d] got v=%b c=%0d exp v=0 c=0", i, out_valid, op_count); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_o;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 2 && i <= 18) begin
        exp_o = 8'(i - 2) ^ 8'hF0;
        tests++; if (out_valid !== 1'b1 || out !== exp_o) begin fails++; $display("FAIL wrap_out[%0d] got v=%b %h exp v=1 %h", i-2, out_valid, out, exp_o); end
      end
      if (i < 17) begin
        in_valid = 1'b1; in1 = 8'(i); in2 = 8'hF0; sel = 3'b010; chain = 1'b0;
        #1;
        if (i == 0) begin
          tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL wrap_first_accept got %b exp 1", in_ready); end
        end
      end else begin
        in_valid = 1'b0; in1 = 'x; in2 = 'x; sel = 'x;
      end
    end
    @(negedge clk);
    tests++; if (op_count !== 16'd17) begin fails++; $display("FAIL wrap_count16 got %0d exp 17", op_count); end
    tests++; if (op_count2 !== 4'd1) begin fails++; $display("FAIL wrap_count4 got %0d exp 1", op_count2); end
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_chain();
    test_back_pressure();
    test_acc_clr();
    test_reset_midflight();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
